// File: rtl/ps2_key_pkg.sv
// rtl/ps2_key_pkg.sv - shared constants, FSM state encoding and event record for the PS/2 key tracker
//
// Contents:
//   PS2_EXT / PS2_BRK / PS2_PAUSE  prefix bytes of the set-2 scan code stream
//   ps2_state_t                    decoder FSM state encoding
//   ps2_evt_t                      event record {brk, code[8:0]} stored in the event FIFO
package ps2_key_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // Code reported for the Pause key once its whole sequence has been swallowed.
    localparam logic [8:0] PS2_PAUSE_CODE = 9'h1E1;

    // ST_SKIP is only reachable when the Pause filter is built in.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } ps2_state_t;

    typedef struct packed {
        logic       brk;
        logic [8:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - small synchronous FIFO carrying key events
//
// Ports:
//   clk, rst   clock and synchronous active-high reset (empties the FIFO)
//   push       write wdata; ignored when full unless a pop happens in the same cycle
//   pop        drop the head entry; ignored when empty
//   wdata      entry to write
//   rdata      head entry (valid while empty is low)
//   full       DEPTH entries stored
//   empty      no entries stored
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // A pop frees a slot in the same cycle, so a push while full still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 scan code decoder with held-key table, repeat suppression and event FIFO
//
// Optional build macro: PS2_PAUSE_FILTER_EN (collapse the E1 Pause sequence into one press event)
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   ps2_data        byte from the PS/2 receiver
//   ps2_ready       receiver has a byte available
//   ps2_nextdata_n  active-low one-cycle pop strobe back to the receiver
//   evt_valid       event FIFO non-empty
//   evt_ready       consumer pops the head event while evt_valid is high
//   evt_code        head event code {extended, scan[7:0]}
//   evt_break       head event is a release (1) or a press (0)
//   press_count     genuine new presses, wraps modulo 2^CNT_W
//   held_count      occupied held-table slots
//   last_code       code of the most recent genuine press
//   key_active      at least one key held
//   evt_overflow    sticky: an event was dropped on a full FIFO
module ps2_key_tracker
    import ps2_key_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int HELD_SLOTS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        ps2_data,
    input  logic                              ps2_ready,
    output logic                              ps2_nextdata_n,
    output logic                              evt_valid,
    input  logic                              evt_ready,
    output logic [8:0]                        evt_code,
    output logic                              evt_break,
    output logic [CNT_W-1:0]                  press_count,
    output logic [$clog2(HELD_SLOTS+1)-1:0]   held_count,
    output logic [8:0]                        last_code,
    output logic                              key_active,
    output logic                              evt_overflow
);

    localparam int HC_W = $clog2(HELD_SLOTS+1);

    ps2_state_t            state;
    ps2_state_t            state_next;
    logic                  accept;
    logic                  ev_make;
    logic                  ev_break;
    logic                  ev_ext;
    logic                  pause_evt;
    logic [8:0]            ev_code;
    logic                  hit;
    logic                  new_press;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    ps2_evt_t              push_evt;
    ps2_evt_t              head_evt;

    logic [HELD_SLOTS-1:0] slot_valid;
    logic [8:0]            slot_code [HELD_SLOTS];
    logic [HELD_SLOTS-1:0] match_mask;
    logic [HELD_SLOTS-1:0] ins_mask;
    logic [HELD_SLOTS-1:0] clr_mask;
    logic [HC_W-1:0]       valid_cnt;

`ifdef PS2_PAUSE_FILTER_EN
    logic [2:0]            skip_cnt;
`endif

    // The strobe low cycle doubles as a guard against re-reading the same byte.
    assign accept = ps2_ready & ps2_nextdata_n;

    always_comb begin
        state_next = state;
        ev_make    = 1'b0;
        ev_break   = 1'b0;
        ev_ext     = 1'b0;
        pause_evt  = 1'b0;
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (ps2_data == PS2_EXT) begin
                        state_next = ST_EXT;
                    end else if (ps2_data == PS2_BRK) begin
                        state_next = ST_BRK;
                    end
`ifdef PS2_PAUSE_FILTER_EN
                    else if (ps2_data == PS2_PAUSE) begin
                        state_next = ST_SKIP;
                        pause_evt  = 1'b1;
                    end
`endif
                    else begin
                        ev_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (ps2_data == PS2_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else begin
                        ev_make    = 1'b1;
                        ev_ext     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    ev_break   = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    ev_break   = 1'b1;
                    ev_ext     = 1'b1;
                    state_next = ST_IDLE;
                end
`ifdef PS2_PAUSE_FILTER_EN
                ST_SKIP: begin
                    if (skip_cnt == 3'd1) begin
                        state_next = ST_IDLE;
                    end
                end
`endif
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign ev_code = {ev_ext, ps2_data};

    // Held-table lookup: at most one slot can match since codes are never stored twice.
    always_comb begin
        match_mask = '0;
        for (int i = 0; i < HELD_SLOTS; i++) begin
            match_mask[i] = slot_valid[i] && (slot_code[i] == ev_code);
        end
    end

    assign hit       = |match_mask;
    assign new_press = (ev_make & ~hit) | pause_evt;
    assign push      = new_press | ev_break;

    // Lowest free slot as a one-hot mask; all-zero when the table is full.
    always_comb begin
        logic found;
        found    = 1'b0;
        ins_mask = '0;
        if (ev_make && !hit) begin
            for (int i = 0; i < HELD_SLOTS; i++) begin
                if (!slot_valid[i] && !found) begin
                    ins_mask[i] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

    assign clr_mask = ev_break ? match_mask : '0;

    always_comb begin
        valid_cnt = '0;
        for (int i = 0; i < HELD_SLOTS; i++) begin
            valid_cnt = valid_cnt + HC_W'(slot_valid[i]);
        end
    end

    assign held_count = valid_cnt;
    assign key_active = (valid_cnt != '0);

    always_comb begin
        push_evt.brk  = ev_break;
        push_evt.code = pause_evt ? PS2_PAUSE_CODE : ev_code;
    end

    assign pop = ~fifo_empty & evt_ready;

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ps2_evt_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_evt),
        .rdata (head_evt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_code  = head_evt.code;
    assign evt_break = head_evt.brk;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            ps2_nextdata_n <= 1'b1;
            press_count    <= '0;
            last_code      <= '0;
            evt_overflow   <= 1'b0;
            slot_valid     <= '0;
        end else begin
            state          <= state_next;
            ps2_nextdata_n <= ~accept;
            if (new_press) begin
                press_count <= press_count + CNT_W'(1);
                last_code   <= push_evt.code;
            end
            if (push && fifo_full && !pop) begin
                evt_overflow <= 1'b1;
            end
            slot_valid <= (slot_valid & ~clr_mask) | ins_mask;
        end
    end

    // Slot codes are qualified by slot_valid, so they need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < HELD_SLOTS; i++) begin
            if (ins_mask[i]) begin
                slot_code[i] <= ev_code;
            end
        end
    end

`ifdef PS2_PAUSE_FILTER_EN
    // Counts the seven bytes that follow the leading E1 of the Pause sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_cnt <= '0;
        end else if (pause_evt) begin
            skip_cnt <= 3'd7;
        end else if (accept && state == ST_SKIP) begin
            skip_cnt <= skip_cnt - 3'd1;
        end
    end
`endif

endmodule
